// File: rtl/fifo_dot_pkg.sv
// -----------------------------------------------------------------------------
// fifo_dot_pkg
// Shared types and default sizing for the FIFO-fed dot-product engine.
//   state_t         : control FSM states (ST_IDLE, ST_RUN, ST_DONE)
//   DEF_DATA_WIDTH  : default operand width
//   DEF_LEN         : default element pairs per dot product
//   DEF_ACC_WIDTH   : default accumulator/result width
// -----------------------------------------------------------------------------
package fifo_dot_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN        = 8;
    localparam int DEF_ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_dot_mac_mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Registered unsigned multiply-accumulate.
//   clk  in   clock (rising edge)
//   rst  in   synchronous active-high reset, clears acc
//   clr  in   synchronous clear of acc (start of a new operation)
//   en   in   accumulate a*b into acc this cycle
//   a, b in   DATA_WIDTH unsigned operands
//   acc  out  ACC_WIDTH accumulator
// Build option FIFO_DOT_MAC_SAT_EN: when defined, an accumulation that would
// overflow clamps acc to all-ones; otherwise acc wraps modulo 2^ACC_WIDTH.
// -----------------------------------------------------------------------------
module mac_unit
    import fifo_dot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    acc_next;

    assign prod     = a * b;
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef FIFO_DOT_MAC_SAT_EN
    // One extra bit catches the carry out; a saturated acc stays all-ones
    // because any further non-zero product overflows again.
    logic [ACC_WIDTH:0] sum;
    assign sum      = {1'b0, acc} + {1'b0, prod_ext};
    assign acc_next = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_next = acc + prod_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fifo_dot_mac.sv
// -----------------------------------------------------------------------------
// fifo_dot_mac
// Drains LEN operand pairs from two FIFOs, accumulates their dot product and
// presents it on result with a one-cycle done pulse.
//   clk      in   clock (rising edge)
//   rst      in   synchronous active-high reset
//   start    in   one-cycle request, honoured only in ST_IDLE
//   a_empty  in   FIFO A empty flag
//   a_rden   out  FIFO A read enable
//   a_data   in   FIFO A registered read data
//   b_empty  in   FIFO B empty flag
//   b_rden   out  FIFO B read enable
//   b_data   in   FIFO B registered read data
//   busy     out  high from the cycle after an accepted start through the done cycle
//   done     out  one-cycle pulse when result updates
//   result   out  last completed dot product
// Build option FIFO_DOT_MAC_SAT_EN selects saturating accumulation (see mac_unit).
//
// FIFO read handshake: a read is issued in a cycle where both empty flags are
// low and fewer than LEN reads have been issued; a_rden and b_rden are then
// both high (they are always equal). The FIFO samples rden on the next edge
// and its data is valid in the following cycle, tracked here by rd_vld.
// -----------------------------------------------------------------------------
module fifo_dot_mac
    import fifo_dot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN        = DEF_LEN,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  a_empty,
    output logic                  a_rden,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_empty,
    output logic                  b_rden,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        issued;
    logic [CW-1:0]        recv;
    logic                 rd_vld;
    logic                 issue;
    logic                 acc_clr;
    logic [ACC_WIDTH-1:0] acc;

    assign issue   = (state == ST_RUN) && !a_empty && !b_empty && (issued < LEN_C);
    assign acc_clr = (state == ST_IDLE) && start;
    assign a_rden  = issue;
    assign b_rden  = issue;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (rd_vld && (recv == LAST_C)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            issued <= '0;
            recv   <= '0;
            rd_vld <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_next;
            rd_vld <= issue;
            if (acc_clr) begin
                issued <= '0;
                recv   <= '0;
            end else begin
                if (issue)  issued <= issued + CW'(1);
                if (rd_vld) recv   <= recv + CW'(1);
            end
            // Outputs are registered, so the done pulse and the new result
            // appear together one edge after ST_DONE; busy is stretched
            // to cover that cycle.
            busy <= (state_next != ST_IDLE) || (state == ST_DONE);
            done <= (state == ST_DONE);
            if (state == ST_DONE) result <= acc;
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (rd_vld),
        .a   (a_data),
        .b   (b_data),
        .acc (acc)
    );

endmodule

// File: tb/tb_fifo_dot_mac.sv
// -----------------------------------------------------------------------------
// tb_fifo_dot_mac
// Directed bench for fifo_dot_mac with two behavioural FIFOs (registered read
// port). DUT built with ACC_WIDTH=16 so the overflow vector is reachable.
// -----------------------------------------------------------------------------
module tb_fifo_dot_mac;
    import fifo_dot_pkg::*;

    localparam int DW  = 8;
    localparam int LN  = 8;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          a_empty, b_empty;
    logic          a_rden, b_rden;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          busy, done;
    logic [AW-1:0] result;

    // Behavioural FIFOs: pointers, bench-side storage.
    logic [DW-1:0] a_mem [0:63];
    logic [DW-1:0] b_mem [0:63];
    int            a_wr = 0, b_wr = 0;
    int            a_rd = 0, b_rd = 0;
    logic          a_force = 1'b0, b_force = 1'b0;

    // Scoreboard counters
    int tests = 0;
    int fails = 0;

    // Monitor counters
    int rd_cnt = 0, dn_cnt = 0, desync = 0, bad_rd = 0;

    assign a_empty = (a_rd == a_wr) || a_force;
    assign b_empty = (b_rd == b_wr) || b_force;

    always #5 clk = ~clk;

    fifo_dot_mac #(
        .DATA_WIDTH (DW),
        .LEN        (LN),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_empty (a_empty),
        .a_rden  (a_rden),
        .a_data  (a_data),
        .b_empty (b_empty),
        .b_rden  (b_rden),
        .b_data  (b_data),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always @(posedge clk) begin
        if (a_rden) begin
            a_data <= a_mem[a_rd % 64];
            a_rd   <= a_rd + 1;
        end
        if (b_rden) begin
            b_data <= b_mem[b_rd % 64];
            b_rd   <= b_rd + 1;
        end
    end

    always @(negedge clk) begin
        if (a_rden) rd_cnt++;
        if (done) dn_cnt++;
        if (a_rden != b_rden) desync++;
        if ((a_rden || b_rden) && (a_empty || b_empty)) bad_rd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        a_mem[a_wr % 64] = av;
        b_mem[b_wr % 64] = bv;
        a_wr++;
        b_wr++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One full operation; the start edge is edge 0, latency counts edges
    // until done is seen.
    task automatic run_dot(input string tag, input int exp_res, input int exp_lat,
                           input bit stall_en, input bit restart_en);
        int n;
        int rd0;
        int dn0;
        int stall_left;
        bit stalled;
        n = 0;
        rd0 = rd_cnt;
        dn0 = dn_cnt;
        stall_left = 0;
        stalled = 1'b0;
        pulse_start();
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (stall_en && !stalled && (rd_cnt - rd0) >= 3) begin
                b_force = 1'b1;
                stall_left = 3;
                stalled = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) b_force = 1'b0;
            end
            if (restart_en && n == 4) start = 1'b1;
            if (restart_en && n == 5) start = 1'b0;
        end
        start = 1'b0;
        b_force = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(LN));
        check({tag, "_done_pulses"}, 32'(dn_cnt - dn0), 32'd1);
    endtask

    initial begin
        int n;
        int rd0;
        int sat_exp;

        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a_rden", 32'(a_rden), 32'd0);
        check("rst_b_rden", 32'(b_rden), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));

        // Basic: A=1..8, B=2 -> 72
        for (int i = 1; i <= 8; i++) push(DW'(i), 8'h02);
        run_dot("basic", 72, LN + 2, 1'b0, 1'b0);

        // A=i, B=9-i -> 120
        for (int i = 1; i <= 8; i++) push(DW'(i), DW'(9 - i));
        run_dot("mixed", 120, LN + 2, 1'b0, 1'b0);

        // B empty forced for 3 cycles after 3 pairs -> done 3 later
        for (int i = 1; i <= 8; i++) push(DW'(i), 8'h02);
        run_dot("stall", 72, LN + 5, 1'b1, 1'b0);

        // Second start in RUN is ignored: A=3, B=1..8 -> 108
        for (int i = 1; i <= 8; i++) push(8'h03, DW'(i));
        run_dot("restart", 108, LN + 2, 1'b0, 1'b1);

        // Overflow: 8 * 255 * 255 = 520200
`ifdef FIFO_DOT_MAC_SAT_EN
        sat_exp = 32'h0000_FFFF;
`else
        sat_exp = 32'h0000_F008;
`endif
        for (int i = 1; i <= 8; i++) push(8'hFF, 8'hFF);
        run_dot("overflow", sat_exp, LN + 2, 1'b0, 1'b0);

        // Reset mid-RUN after 4 reads
        for (int i = 1; i <= 8; i++) push(DW'(i), 8'h02);
        rd0 = rd_cnt;
        pulse_start();
        n = 0;
        while ((rd_cnt - rd0) < 4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_reads_reached", 32'((rd_cnt - rd0) >= 4), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("midrst_a_rden", 32'(a_rden), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        // Discard leftovers, refill and run fresh: A=3, B=1..8 -> 108
        a_wr = a_rd;
        b_wr = b_rd;
        for (int i = 1; i <= 8; i++) push(8'h03, DW'(i));
        run_dot("after_rst", 108, LN + 2, 1'b0, 1'b0);

        check("rden_desync", 32'(desync), 32'd0);
        check("read_while_empty", 32'(bad_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
